// File: rtl/priv_1_12_trap_sequencer.sv
// Machine-mode trap/return sequencer: latches a trap, waits for the pipeline to drain, then commits the CSR updates and redirects the PC.
// Define PRIV_VECTORED_MODE_EN to let interrupts use mtvec vectored mode (base + 4*cause).
package priv_1_12_trap_pkg;
  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [18:0] rsvd_hi;
    logic [1:0]  mpp;
    logic [2:0]  rsvd_mid;
    logic        mpie;
    logic [2:0]  rsvd_lo2;
    logic        mie;
    logic [2:0]  rsvd_lo;
  } mstatus_t;

  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic        meie;
    logic [2:0]  rsvd_b;
    logic        mtie;
    logic [2:0]  rsvd_a;
    logic        msie;
    logic [2:0]  rsvd_0;
  } mie_t;

  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic        meip;
    logic [2:0]  rsvd_b;
    logic        mtip;
    logic [2:0]  rsvd_a;
    logic        msip;
    logic [2:0]  rsvd_0;
  } mip_t;

  typedef struct packed {
    logic [29:0] base;
    logic [1:0]  mode;
  } mtvec_t;

  typedef struct packed {
    logic        is_intr;
    logic [30:0] code;
  } mcause_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CLEAR,
    ST_COMMIT,
    ST_RET_WAIT,
    ST_RET_COMMIT
  } state_e;

  localparam logic [1:0] PRIV_M         = 2'b11;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  localparam logic [3:0] CAUSE_MAL_INSN    = 4'd0;
  localparam logic [3:0] CAUSE_FAULT_INSN  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT  = 4'd3;
  localparam logic [3:0] CAUSE_MAL_L       = 4'd4;
  localparam logic [3:0] CAUSE_FAULT_L     = 4'd5;
  localparam logic [3:0] CAUSE_MAL_S       = 4'd6;
  localparam logic [3:0] CAUSE_FAULT_S     = 4'd7;
  localparam logic [3:0] CAUSE_ENV_M       = 4'd11;
  localparam logic [3:0] CAUSE_MSI         = 4'd3;
  localparam logic [3:0] CAUSE_MTI         = 4'd7;
  localparam logic [3:0] CAUSE_MEI         = 4'd11;

  // Pending register bit positions, {MEIP, MSIP, MTIP}.
  localparam int PEND_MEI = 2;
  localparam int PEND_MSI = 1;
  localparam int PEND_MTI = 0;
endpackage

module priv_1_12_trap_sequencer
  import priv_1_12_trap_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     mal_insn,
  input  logic     fault_insn_access,
  input  logic     illegal_insn,
  input  logic     breakpoint,
  input  logic     env_m,
  input  logic     mal_l,
  input  logic     fault_l,
  input  logic     mal_s,
  input  logic     fault_s,
  input  word_t    ex_tval,
  input  logic     timer_int_m,
  input  logic     soft_int_m,
  input  logic     ext_int_m,
  input  logic     clear_timer_int_m,
  input  logic     clear_soft_int_m,
  input  logic     clear_ext_int_m,
  input  word_t    epc,
  input  logic     mret,
  input  logic     pipe_clear,
  input  mstatus_t curr_mstatus,
  input  mie_t     curr_mie,
  input  mtvec_t   curr_mtvec,
  input  word_t    curr_mepc,
  output logic     intr,
  output logic     inject_mcause,
  output logic     inject_mepc,
  output logic     inject_mstatus,
  output logic     inject_mtval,
  output logic     inject_mip,
  output mcause_t  next_mcause,
  output word_t    next_mepc,
  output mstatus_t next_mstatus,
  output word_t    next_mtval,
  output mip_t     next_mip,
  output logic     insert_pc,
  output word_t    priv_pc
);

  state_e     state_q, state_d;
  logic [2:0] pend_q, pend_d;
  logic [3:0] cause_q, cause_d;
  logic       irq_q, irq_d;
  word_t      epc_q, epc_d;
  word_t      tval_q, tval_d;

  logic       exc_valid;
  logic [3:0] exc_code;
  logic [2:0] irq_en;
  logic       irq_valid;
  logic [3:0] irq_code;
  word_t      trap_pc;
  logic       unused_inputs;

  assign unused_inputs = ^{curr_mie.rsvd_hi, curr_mie.rsvd_b, curr_mie.rsvd_a,
                           curr_mie.rsvd_0, curr_mtvec.mode, epc[0]};

  always_comb begin
    exc_valid = 1'b1;
    exc_code  = CAUSE_MAL_INSN;
    if (breakpoint)             exc_code = CAUSE_BREAKPOINT;
    else if (fault_insn_access) exc_code = CAUSE_FAULT_INSN;
    else if (illegal_insn)      exc_code = CAUSE_ILLEGAL;
    else if (mal_insn)          exc_code = CAUSE_MAL_INSN;
    else if (env_m)             exc_code = CAUSE_ENV_M;
    else if (mal_l)             exc_code = CAUSE_MAL_L;
    else if (fault_l)           exc_code = CAUSE_FAULT_L;
    else if (mal_s)             exc_code = CAUSE_MAL_S;
    else if (fault_s)           exc_code = CAUSE_FAULT_S;
    else                        exc_valid = 1'b0;
  end

  assign irq_en = curr_mstatus.mie ? {curr_mie.meie & pend_q[PEND_MEI],
                                      curr_mie.msie & pend_q[PEND_MSI],
                                      curr_mie.mtie & pend_q[PEND_MTI]} : 3'b000;
  assign irq_valid = |irq_en;

  always_comb begin
    irq_code = CAUSE_MTI;
    if (irq_en[PEND_MEI])      irq_code = CAUSE_MEI;
    else if (irq_en[PEND_MSI]) irq_code = CAUSE_MSI;
  end

  // NOTE: every always_comb assigns its outputs a default first so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    irq_d   = irq_q;
    epc_d   = epc_q;
    tval_d  = tval_q;

    // A clear request beats a set request arriving in the same cycle.
    pend_d[PEND_MEI] = clear_ext_int_m   ? 1'b0 : (ext_int_m   | pend_q[PEND_MEI]);
    pend_d[PEND_MSI] = clear_soft_int_m  ? 1'b0 : (soft_int_m  | pend_q[PEND_MSI]);
    pend_d[PEND_MTI] = clear_timer_int_m ? 1'b0 : (timer_int_m | pend_q[PEND_MTI]);

    unique case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          cause_d = exc_code;
          irq_d   = 1'b0;
          epc_d   = {epc[31:1], 1'b0};
          tval_d  = ex_tval;
          state_d = ST_WAIT_CLEAR;
        end else if (irq_valid) begin
          cause_d = irq_code;
          irq_d   = 1'b1;
          epc_d   = {epc[31:1], 1'b0};
          tval_d  = '0;
          state_d = ST_WAIT_CLEAR;
        end else if (mret) begin
          state_d = ST_RET_WAIT;
        end
      end
      ST_WAIT_CLEAR: if (pipe_clear) state_d = ST_COMMIT;
      ST_COMMIT:     state_d = ST_IDLE;
      ST_RET_WAIT:   if (pipe_clear) state_d = ST_RET_COMMIT;
      ST_RET_COMMIT: state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    trap_pc = {curr_mtvec.base, 2'b00};
`ifdef PRIV_VECTORED_MODE_EN
    if (irq_q && (curr_mtvec.mode == MTVEC_VECTORED))
      trap_pc = {curr_mtvec.base, 2'b00} + {26'd0, cause_q, 2'b00};
`else
`endif
  end

  always_comb begin
    intr           = (state_q == ST_WAIT_CLEAR) || (state_q == ST_COMMIT);
    inject_mcause  = 1'b0;
    inject_mepc    = 1'b0;
    inject_mstatus = 1'b0;
    inject_mtval   = 1'b0;
    insert_pc      = 1'b0;
    next_mcause    = '0;
    next_mepc      = '0;
    next_mstatus   = '0;
    next_mtval     = '0;
    priv_pc        = '0;
    // mip is written back every cycle, but held off while in reset.
    inject_mip       = ~RST;
    next_mip         = '0;
    next_mip.meip    = pend_q[PEND_MEI];
    next_mip.msip    = pend_q[PEND_MSI];
    next_mip.mtip    = pend_q[PEND_MTI];

    unique case (state_q)
      ST_COMMIT: begin
        inject_mcause       = 1'b1;
        inject_mepc         = 1'b1;
        inject_mstatus      = 1'b1;
        inject_mtval        = 1'b1;
        insert_pc           = 1'b1;
        next_mcause.is_intr = irq_q;
        next_mcause.code    = {27'd0, cause_q};
        next_mepc           = epc_q;
        next_mtval          = tval_q;
        next_mstatus        = curr_mstatus;
        next_mstatus.mpie   = curr_mstatus.mie;
        next_mstatus.mie    = 1'b0;
        next_mstatus.mpp    = PRIV_M;
        priv_pc             = trap_pc;
      end
      ST_RET_COMMIT: begin
        inject_mstatus    = 1'b1;
        insert_pc         = 1'b1;
        next_mstatus      = curr_mstatus;
        next_mstatus.mie  = curr_mstatus.mpie;
        next_mstatus.mpie = 1'b1;
        next_mstatus.mpp  = PRIV_M;
        priv_pc           = curr_mepc;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      cause_q <= '0;
      irq_q   <= 1'b0;
      epc_q   <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
      irq_q   <= irq_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
    end
  end

endmodule

// File: tb/tb_priv_1_12_trap_sequencer.sv
// Bench for priv_1_12_trap_sequencer: a transaction-level model checked every cycle, plus directed
// scenarios with hand-computed expectations. The bench also plays the CSR file (mstatus/mepc write-back).
module tb_priv_1_12_trap_sequencer;
  logic CLK = 1'b0;
  logic RST;
  logic mal_insn, fault_insn_access, illegal_insn, breakpoint, env_m, mal_l, fault_l, mal_s, fault_s;
  logic [31:0] ex_tval, epc;
  logic timer_int_m, soft_int_m, ext_int_m;
  logic clear_timer_int_m, clear_soft_int_m, clear_ext_int_m;
  logic mret, pipe_clear;
  logic [31:0] curr_mstatus, curr_mie, curr_mtvec, curr_mepc;
  logic intr, inject_mcause, inject_mepc, inject_mstatus, inject_mtval, inject_mip, insert_pc;
  logic [31:0] next_mcause, next_mepc, next_mstatus, next_mtval, next_mip, priv_pc;

  priv_1_12_trap_sequencer dut (
    .CLK(CLK), .RST(RST),
    .mal_insn(mal_insn), .fault_insn_access(fault_insn_access), .illegal_insn(illegal_insn),
    .breakpoint(breakpoint), .env_m(env_m), .mal_l(mal_l), .fault_l(fault_l),
    .mal_s(mal_s), .fault_s(fault_s), .ex_tval(ex_tval),
    .timer_int_m(timer_int_m), .soft_int_m(soft_int_m), .ext_int_m(ext_int_m),
    .clear_timer_int_m(clear_timer_int_m), .clear_soft_int_m(clear_soft_int_m),
    .clear_ext_int_m(clear_ext_int_m), .epc(epc), .mret(mret), .pipe_clear(pipe_clear),
    .curr_mstatus(curr_mstatus), .curr_mie(curr_mie), .curr_mtvec(curr_mtvec), .curr_mepc(curr_mepc),
    .intr(intr), .inject_mcause(inject_mcause), .inject_mepc(inject_mepc),
    .inject_mstatus(inject_mstatus), .inject_mtval(inject_mtval), .inject_mip(inject_mip),
    .next_mcause(next_mcause), .next_mepc(next_mepc), .next_mstatus(next_mstatus),
    .next_mtval(next_mtval), .next_mip(next_mip), .insert_pc(insert_pc), .priv_pc(priv_pc)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // m_kind: 0 nothing outstanding, 1 trap outstanding, 2 mret outstanding.
  // m_fire: this cycle is the single commit cycle of the outstanding item.
  int          m_kind;
  bit          m_fire;
  int          m_cause;
  bit          m_irq;
  logic [31:0] m_epc, m_tval;
  bit          m_mei, m_msi, m_mti;

  function automatic int pick_exc();
    bit hits[9];
    int codes[9];
    codes = '{3, 1, 2, 0, 11, 4, 5, 6, 7};
    hits  = '{breakpoint, fault_insn_access, illegal_insn, mal_insn, env_m,
              mal_l, fault_l, mal_s, fault_s};
    for (int i = 0; i < 9; i++) if (hits[i]) return codes[i];
    return -1;
  endfunction

  function automatic int pick_irq();
    if (!curr_mstatus[3]) return -1;
    if (curr_mie[11] && m_mei) return 11;
    if (curr_mie[3]  && m_msi) return 3;
    if (curr_mie[7]  && m_mti) return 7;
    return -1;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_kind <= 0; m_fire <= 1'b0; m_cause <= 0; m_irq <= 1'b0;
      m_epc <= '0; m_tval <= '0; m_mei <= 1'b0; m_msi <= 1'b0; m_mti <= 1'b0;
    end else begin
      m_mei <= clear_ext_int_m   ? 1'b0 : (ext_int_m   ? 1'b1 : m_mei);
      m_msi <= clear_soft_int_m  ? 1'b0 : (soft_int_m  ? 1'b1 : m_msi);
      m_mti <= clear_timer_int_m ? 1'b0 : (timer_int_m ? 1'b1 : m_mti);
      if (m_fire) begin
        m_kind <= 0;
        m_fire <= 1'b0;
      end else if (m_kind != 0) begin
        if (pipe_clear) m_fire <= 1'b1;
      end else if (pick_exc() >= 0) begin
        m_kind <= 1; m_cause <= pick_exc(); m_irq <= 1'b0;
        m_epc <= epc & ~32'd1; m_tval <= ex_tval;
      end else if (pick_irq() >= 0) begin
        m_kind <= 1; m_cause <= pick_irq(); m_irq <= 1'b1;
        m_epc <= epc & ~32'd1; m_tval <= '0;
      end else if (mret) begin
        m_kind <= 2;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin : cmp
    logic [31:0] e_mcause, e_mepc, e_ms, e_mtval, e_pc, e_mip;
    logic [5:0]  e_strb;
    e_mcause = '0; e_mepc = '0; e_ms = '0; e_mtval = '0; e_pc = '0;
    e_mip    = ({31'd0, m_mei} << 11) | ({31'd0, m_mti} << 7) | ({31'd0, m_msi} << 3);
    e_strb   = {5'b00000, ~RST};
    if (m_kind == 1 && m_fire) begin
      e_strb   = {5'b11111, ~RST};
      e_mcause = (m_irq ? 32'h8000_0000 : 32'h0) | 32'(m_cause);
      e_mepc   = m_epc;
      e_mtval  = m_tval;
      e_ms     = (curr_mstatus & ~32'h0000_1888) | ({31'd0, curr_mstatus[3]} << 7) | 32'h1800;
      e_pc     = curr_mtvec & ~32'd3;
`ifdef PRIV_VECTORED_MODE_EN
      if (m_irq && curr_mtvec[1:0] == 2'b01) e_pc = e_pc + 32'(4 * m_cause);
`endif
    end else if (m_kind == 2 && m_fire) begin
      e_strb = {2'b00, 1'b1, 1'b0, 1'b1, ~RST};
      e_ms   = (curr_mstatus & ~32'h0000_1888) | ({31'd0, curr_mstatus[7]} << 3) | 32'h1880;
      e_pc   = curr_mepc;
    end
    check("cyc intr", {31'd0, intr}, {31'd0, (m_kind == 1)});
    check("cyc strobes", {26'd0, inject_mcause, inject_mepc, inject_mstatus, inject_mtval,
                          insert_pc, inject_mip}, {26'd0, e_strb});
    check("cyc next_mcause",  next_mcause,  e_mcause);
    check("cyc next_mepc",    next_mepc,    e_mepc);
    check("cyc next_mstatus", next_mstatus, e_ms);
    check("cyc next_mtval",   next_mtval,   e_mtval);
    check("cyc next_mip",     next_mip,     e_mip);
    check("cyc priv_pc",      priv_pc,      e_pc);
  end

  // ---------------- driver ----------------
  logic        s_intr, s_imc, s_imepc, s_ims, s_imtval, s_imip, s_ipc;
  logic [31:0] s_nmc, s_nmepc, s_nms, s_nmtval, s_nmip, s_pc;

  task automatic cyc();
    @(negedge CLK);
    s_intr = intr; s_imc = inject_mcause; s_imepc = inject_mepc; s_ims = inject_mstatus;
    s_imtval = inject_mtval; s_imip = inject_mip; s_ipc = insert_pc;
    s_nmc = next_mcause; s_nmepc = next_mepc; s_nms = next_mstatus;
    s_nmtval = next_mtval; s_nmip = next_mip; s_pc = priv_pc;
    @(posedge CLK);
    #1;
    if (s_ims)   curr_mstatus = s_nms;
    if (s_imepc) curr_mepc    = s_nmepc;
    {mal_insn, fault_insn_access, illegal_insn, breakpoint, env_m, mal_l, fault_l, mal_s, fault_s} = '0;
    {timer_int_m, soft_int_m, ext_int_m, clear_timer_int_m, clear_soft_int_m, clear_ext_int_m} = '0;
    mret = 1'b0;
  endtask

  task automatic wait_evt(input string name, input bit want_ret, input int budget);
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (want_ret ? (s_ims && s_ipc && !s_imc) : s_imc) return;
    end
    n_checks++;
    $display("FAIL %s: event not seen within %0d cycles", name, budget);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    curr_mstatus = '0; curr_mie = '0; curr_mtvec = '0; curr_mepc = '0;
    pipe_clear = 1'b0; epc = '0; ex_tval = '0;
    cyc();
    cyc();
    check("reset inject_mip", {31'd0, s_imip}, 32'd0);
    check("reset intr/strobes", {25'd0, s_intr, s_imc, s_imepc, s_ims, s_imtval, s_ipc, s_imip}, 32'd0);
    check("reset next_mip", s_nmip, 32'd0);
    RST = 1'b0;
    cyc();
    check("post-reset inject_mip", {31'd0, s_imip}, 32'd1);
  endtask

  int n_hit;
  int n_pulses;

  initial begin
    RST = 1'b1;
    {mal_insn, fault_insn_access, illegal_insn, breakpoint, env_m, mal_l, fault_l, mal_s, fault_s} = '0;
    {timer_int_m, soft_int_m, ext_int_m, clear_timer_int_m, clear_soft_int_m, clear_ext_int_m} = '0;
    mret = 1'b0; pipe_clear = 1'b0; ex_tval = '0; epc = '0;
    curr_mstatus = '0; curr_mie = '0; curr_mtvec = '0; curr_mepc = '0;

    // Scenario 1: illegal instruction, pipe_clear rises 3 cycles later.
    do_reset();
    curr_mtvec = 32'h1001; curr_mstatus = 32'h8;
    illegal_insn = 1'b1; epc = 32'h200; ex_tval = 32'hDEAD;
    cyc();
    check("s1 intr in latch cycle", {31'd0, s_intr}, 32'd0);
    n_hit = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) pipe_clear = 1'b1;
      cyc();
      if (k == 1) check("s1 intr after latch", {31'd0, s_intr}, 32'd1);
      if (s_imc) begin n_hit = k; break; end
    end
    check("s1 commit cycle", n_hit, 4);
    check("s1 mcause", s_nmc, 32'h0000_0002);
    check("s1 mepc", s_nmepc, 32'h200);
    check("s1 mtval", s_nmtval, 32'hDEAD);
    check("s1 priv_pc", s_pc, 32'h1000);
    check("s1 mstatus.mie", {31'd0, s_nms[3]}, 32'd0);
    check("s1 intr in commit", {31'd0, s_intr}, 32'd1);
    pipe_clear = 1'b0;
    cyc();
    check("s1 intr after commit", {31'd0, s_intr}, 32'd0);

    // Scenario 2: external interrupt with vectored mtvec, then mret.
    do_reset();
    curr_mtvec = 32'h1001; curr_mstatus = 32'h8; curr_mie = 32'h800; pipe_clear = 1'b1;
    epc = 32'h305; ext_int_m = 1'b1;
    cyc();
    wait_evt("s2 trap", 1'b0, 8);
    check("s2 mcause", s_nmc, 32'h8000_000B);
`ifdef PRIV_VECTORED_MODE_EN
    check("s2 priv_pc", s_pc, 32'h102C);
`else
    check("s2 priv_pc", s_pc, 32'h1000);
`endif
    check("s2 mepc", s_nmepc, 32'h304);
    check("s2 mtval", s_nmtval, 32'h0);
    check("s2 mstatus", s_nms, 32'h1880);
    clear_ext_int_m = 1'b1;
    cyc();
    mret = 1'b1;
    cyc();
    wait_evt("s2 mret", 1'b1, 8);
    check("s2 ret priv_pc", s_pc, 32'h304);
    check("s2 ret mstatus", s_nms, 32'h1888);

    // Scenario 3: timer and external together; MEI first, MTI after mret.
    do_reset();
    curr_mtvec = 32'h2000; curr_mstatus = 32'h8; curr_mie = 32'h880; pipe_clear = 1'b1;
    epc = 32'h500; timer_int_m = 1'b1; ext_int_m = 1'b1;
    cyc();
    wait_evt("s3 first trap", 1'b0, 8);
    check("s3 first mcause", s_nmc, 32'h8000_000B);
    clear_ext_int_m = 1'b1;
    cyc();
    mret = 1'b1;
    cyc();
    wait_evt("s3 first mret", 1'b1, 8);
    wait_evt("s3 second trap", 1'b0, 8);
    check("s3 second mcause", s_nmc, 32'h8000_0007);
    check("s3 second priv_pc", s_pc, 32'h2000);
    clear_timer_int_m = 1'b1;
    cyc();
    mret = 1'b1;
    cyc();
    wait_evt("s3 second mret", 1'b1, 8);

    // Scenario 4: exception, enabled interrupt and mret in one cycle.
    do_reset();
    curr_mtvec = 32'h3000; curr_mie = 32'h800; pipe_clear = 1'b1;
    ext_int_m = 1'b1;
    cyc();
    curr_mstatus = 32'h8; illegal_insn = 1'b1; mret = 1'b1; ex_tval = 32'h1234; epc = 32'h400;
    cyc();
    wait_evt("s4 trap", 1'b0, 8);
    check("s4 mcause", s_nmc, 32'h0000_0002);
    check("s4 mtval", s_nmtval, 32'h1234);
    check("s4 priv_pc", s_pc, 32'h3000);
    n_pulses = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (s_ipc) n_pulses++;
    end
    check("s4 dropped mret pc pulses", n_pulses, 0);

    // Scenario 5: set/clear collision, then reset in WAIT_CLEAR.
    do_reset();
    timer_int_m = 1'b1;
    cyc();
    cyc();
    check("s5 mtip set", s_nmip, 32'h80);
    timer_int_m = 1'b1; clear_timer_int_m = 1'b1;
    cyc();
    cyc();
    check("s5 set+clear mtip", s_nmip, 32'h0);
    illegal_insn = 1'b1; epc = 32'h600; ex_tval = 32'h77;
    cyc();
    cyc();
    check("s5 intr in wait", {31'd0, s_intr}, 32'd1);
    RST = 1'b1;
    cyc();
    check("s5 intr in reset", {31'd0, s_intr}, 32'd0);
    check("s5 inject_mip in reset", {31'd0, s_imip}, 32'd0);
    RST = 1'b0; pipe_clear = 1'b1;
    n_pulses = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (k == 0) check("s5 inject_mip after release", {31'd0, s_imip}, 32'd1);
      if (s_imc || s_imepc || s_ims || s_imtval || s_ipc) n_pulses++;
      if (s_intr) n_pulses++;
    end
    check("s5 abandoned trap pulses", n_pulses, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
